// File: rtl/seq_det_pkg.sv
// Shared types and constants for the word-level scheduler and its bit-serial
// run-end detector.
package seq_det_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SHIFT = 3'd1,
    FLUSH = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } sched_state_e;

  // Length of the current run of 1s; R3 saturates.
  typedef enum logic [1:0] {
    R0 = 2'd0,
    R1 = 2'd1,
    R2 = 2'd2,
    R3 = 2'd3
  } run_state_e;

  typedef struct packed {
    sched_state_e state;
    run_state_e   run_state;
  } sched_dbg_t;

  localparam int MIN_RUN_LO = 1;
  localparam int MIN_RUN_HI = 3;

  function automatic int clamp_min_run(input int m);
    if (m < MIN_RUN_LO) return MIN_RUN_LO;
    if (m > MIN_RUN_HI) return MIN_RUN_HI;
    return m;
  endfunction

  function automatic run_state_e run_next(input run_state_e r, input logic x);
    if (!x) return R0;
    case (r)
      R0:      return R1;
      R1:      return R2;
      default: return R3;
    endcase
  endfunction

endpackage

// File: rtl/run_end_det.sv
// Bit-serial detector: registers a hit pulse when a run of at least MIN_RUN
// consecutive 1s is ended by a 0.
module run_end_det
  import seq_det_pkg::*;
#(
  parameter int MIN_RUN = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic       x,
  output logic       y,
  output run_state_e run_state
);

  localparam int MIN_EFF = clamp_min_run(MIN_RUN);

  logic run_long;

  assign run_long = (int'(run_state) >= MIN_EFF);

  // y is a one-cycle pulse: it drops whenever the detector is not stepped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_state <= R0;
      y         <= 1'b0;
    end else if (clr) begin
      run_state <= R0;
      y         <= 1'b0;
    end else if (en) begin
      run_state <= run_next(run_state, x);
      y         <= ~x & run_long;
    end else begin
      y         <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_det_scheduler.sv
// Word-level front end for run_end_det: shifts a word MSB-first plus one
// terminator 0 through the detector and returns the number of hits.
module seq_det_scheduler
  import seq_det_pkg::*;
#(
  parameter  int W       = 8,
  parameter  int MIN_RUN = 2,
  localparam int CNT_W   = $clog2(W + 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_word,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] hit_count,
  output logic             bit_out,
  output logic             det_y,
  output sched_dbg_t       dbg
);

  localparam int IDX_W = (W > 1) ? $clog2(W) : 1;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready depends only on state, never on valid, and the producer
  // holds its word until the transfer.
  sched_state_e     state, state_nxt;
  logic [W-1:0]     shreg;
  logic [IDX_W-1:0] idx;
  logic             last_idx;
  logic             busy;
  logic             load;
  logic             det_en;
  logic             det_clr;
  logic             cnt_en;
  run_state_e       run_state;

  assign last_idx = (idx == IDX_W'(W - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = SHIFT;
      SHIFT:   if (abort) state_nxt = IDLE;
               else if (last_idx) state_nxt = FLUSH;
      FLUSH:   state_nxt = abort ? IDLE : DRAIN;
      DRAIN:   state_nxt = abort ? IDLE : DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    bit_out   = 1'b0;
    busy      = 1'b0;
    load      = 1'b0;
    det_en    = 1'b0;
    det_clr   = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        load     = in_valid;
        det_clr  = in_valid;
      end
      // det_y in the first SHIFT cycle still belongs to the cleared detector.
      SHIFT: begin
        busy    = 1'b1;
        bit_out = shreg[W-1];
        det_en  = 1'b1;
        cnt_en  = det_y && (idx != '0);
      end
      FLUSH: begin
        busy   = 1'b1;
        det_en = 1'b1;
        cnt_en = det_y;
      end
      DRAIN: begin
        busy   = 1'b1;
        cnt_en = det_y;
      end
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg     <= '0;
      idx       <= '0;
      hit_count <= '0;
    end else if (load) begin
      shreg     <= in_word;
      idx       <= '0;
      hit_count <= '0;
    end else if (busy && abort) begin
      hit_count <= '0;
    end else begin
      if (state == SHIFT) begin
        shreg <= {shreg[W-2:0], 1'b0};
        idx   <= idx + 1'b1;
      end
      if (cnt_en && (hit_count != '1)) hit_count <= hit_count + 1'b1;
    end
  end

  run_end_det #(
    .MIN_RUN(MIN_RUN)
  ) u_det (
    .clk      (clk),
    .rst      (rst),
    .en       (det_en),
    .clr      (det_clr),
    .x        (bit_out),
    .y        (det_y),
    .run_state(run_state)
  );

  assign dbg.state     = state;
  assign dbg.run_state = run_state;

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Directed bench: two schedulers (MIN_RUN=2 and MIN_RUN=1) share all inputs
// and run in lockstep; expected hit counts are worked out by hand.
module tb_seq_det_scheduler;
  import seq_det_pkg::*;

  localparam int W     = 8;
  localparam int CNT_W = $clog2(W + 2);

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [W-1:0]     in_word;
  logic             abort;
  logic             out_ready;
  logic             in_ready,  in_ready1;
  logic             out_valid, out_valid1;
  logic [CNT_W-1:0] hit_count, hit_count1;
  logic             bit_out,   bit_out1;
  logic             det_y,     det_y1;
  sched_dbg_t       dbg,       dbg1;

  int checks = 0;
  int errors = 0;

  seq_det_scheduler #(.W(W), .MIN_RUN(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_word(in_word), .abort(abort), .out_valid(out_valid),
    .out_ready(out_ready), .hit_count(hit_count), .bit_out(bit_out),
    .det_y(det_y), .dbg(dbg)
  );

  seq_det_scheduler #(.W(W), .MIN_RUN(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_word(in_word), .abort(abort), .out_valid(out_valid1),
    .out_ready(out_ready), .hit_count(hit_count1), .bit_out(bit_out1),
    .det_y(det_y1), .dbg(dbg1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scans one word: checks the bit stream, the accept-to-out_valid latency,
  // both hit counts, stability under a stalled consumer, and the return to IDLE.
  task automatic run_word(input logic [W-1:0] w, input int exp2, input int exp1,
                          input int stall);
    int n;
    in_word  = w;
    in_valid = 1'b1;
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      if (n < W) check("shift_bit", bit_out, w[W-1-n]);
      else if (n == W) check("flush_bit", bit_out, 1'b0);
      step();
      n++;
    end
    check("latency", n, W + 2);
    check("hit_count_min2", hit_count, exp2);
    check("hit_count_min1", hit_count1, exp1);
    check("in_ready_done", in_ready, 1'b0);
    for (int i = 0; i < stall; i++) begin
      step();
      check("stall_out_valid", out_valid, 1'b1);
      check("stall_hit_count", hit_count, exp2);
      check("stall_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("idle_in_ready", in_ready, 1'b1);
    check("idle_out_valid", out_valid, 1'b0);
  endtask

  initial begin
    int n;
    int seen_valid;
    rst = 1'b0;
    in_valid = 1'b0;
    in_word = '0;
    abort = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_hit_count", hit_count, 0);
    check("rst_bit_out", bit_out, 1'b0);
    check("rst_det_y", det_y, 1'b0);
    check("rst_state", dbg.state, IDLE);
    check("rst_run_state", dbg.run_state, R0);
    rst = 1'b1;
    step();

    run_word(8'b0110_1110, 2, 2, 0);

    // reset in the middle of SHIFT
    in_word  = 8'b1111_0000;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    rst = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_hit_count", hit_count, 0);
    check("midrst_bit_out", bit_out, 1'b0);
    check("midrst_run_state", dbg.run_state, R0);
    step();
    rst = 1'b1;
    step();

    run_word(8'b0110_1110, 2, 2, 0);
    run_word(8'hFF, 1, 1, 0);
    run_word(8'h00, 0, 0, 0);
    run_word(8'b1010_1010, 0, 4, 0);
    run_word(8'b1101_1011, 3, 3, 5);

    // abort in the 4th SHIFT cycle; the run "11" has just ended, so det_y=1
    in_word  = 8'b1100_0000;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    check("abort_det_y", det_y, 1'b1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_in_ready", in_ready, 1'b1);
    check("abort_out_valid", out_valid, 1'b0);
    check("abort_hit_count", hit_count, 0);
    seen_valid = 0;
    for (int i = 0; i < 14; i++) begin
      if (out_valid === 1'b1) seen_valid++;
      step();
    end
    check("abort_no_result", seen_valid, 0);

    // back-to-back: in_valid and out_ready held high
    in_word   = 8'hFF;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (in_ready !== 1'b1 && n < 40) begin
        step();
        n++;
      end
      check("b2b_idle_wait", n, (k == 0) ? 0 : 1);
      step();
      check("b2b_busy_ready", in_ready, 1'b0);
      n = 0;
      while (out_valid !== 1'b1 && n < 40) begin
        step();
        n++;
      end
      check("b2b_latency", n, W + 2);
      check("b2b_hit_count", hit_count, 1);
    end
    in_valid  = 1'b0;
    step();
    out_ready = 1'b0;
    step();
    check("end_in_ready", in_ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_det_scheduler.md
Name: seq_det_scheduler

Overview:
Serial-stream scheduler for the run-end sequence detector.
- Accepts a W-bit word over a valid/ready handshake.
- Feeds the word MSB-first, one bit per clock, into an embedded detector, followed by one terminator 0 bit.
- Counts the detector's registered hit pulses and returns the count over a valid/ready result handshake.
- Sits between the word-level test/control logic and the bit-serial detector.

Parameters:
W, 8, input word width (2..32)
MIN_RUN, 2, minimum run of consecutive 1s, ended by a 0, that counts as a hit (1..3)
CNT_W, $clog2(W+2), hit-count width (derived; not overridden)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-low reset
in_valid  input  1  word offered
in_ready  output  1  scheduler can accept a word (high only in IDLE)
in_word  input  W  word to scan, MSB first
abort  input  1  synchronous abort of the current scan
out_valid  output  1  result available (high only in DONE)
out_ready  input  1  consumer takes the result
hit_count  output  CNT_W  number of hits in the last scanned word
bit_out  output  1  bit presented to the detector this cycle (debug)
det_y  output  1  detector registered hit output (debug)

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-low. All flops clear immediately on rst low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, hit_count=0, bit_out=0, det_y=0, detector state=R0.
- Detector (sub-module) states: R0 (no run), R1, R2, R3 (run ≥3, saturating).
  - When en=1: x=1 advances R0→R1→R2→R3→R3; x=0 → R0.
  - y <= en & ~x & (run ≥ MIN_RUN). y is registered, so it is valid the cycle after the bit is applied.
  - When en=0: state and y hold, except that y clears to 0.
  - clr (synchronous): forces R0 and y=0. clr has priority over en.
- Scheduler FSM: IDLE, SHIFT, FLUSH, DRAIN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_word into the shift register, clear hit_count, pulse detector clr, bit index=0, go to SHIFT.
- SHIFT (W cycles):
  - bit_out=word[W-1-idx], detector en=1, idx increments.
  - After the cycle with idx=W-1, go to FLUSH.
- FLUSH (1 cycle): bit_out=0, en=1. The terminator bit ends any trailing run, so a trailing run ≥MIN_RUN counts as a hit. Then go to DRAIN.
- DRAIN (1 cycle): en=0. Captures det_y produced by the FLUSH bit. Then go to DONE.
- Hit counting: in SHIFT (from its 2nd cycle onward), FLUSH and DRAIN, each cycle with det_y=1 increments hit_count. The count saturates at all-ones; this is unreachable for legal W.
- DONE:
  - out_valid=1; hit_count is stable.
  - On out_ready: go to IDLE. in_ready rises the next cycle; a word cannot be accepted in the DONE cycle itself.
- Latency: the in_valid accept edge is cycle 0. SHIFT occupies cycles 1..W, FLUSH W+1, DRAIN W+2, out_valid from W+3.
- abort:
  - In SHIFT, FLUSH or DRAIN: go to IDLE on the next edge; out_valid stays 0; hit_count is discarded (cleared).
  - Ignored in IDLE and DONE.
- Simultaneous events:
  - abort together with the last SHIFT cycle: abort wins.
  - in_valid while busy: not accepted (in_ready=0); the word must be held by the producer.
- Reset mid-scan: immediate return to the reset values; no partial result is emitted.

Decomposition:
- Shared package seq_det_pkg:
  - scheduler state enum (IDLE, SHIFT, FLUSH, DRAIN, DONE);
  - detector run-state enum (R0..R3);
  - MIN_RUN legal-range constants.
- One sub-module, run_end_det (clk, rst, en, clr, x, y, run_state), instantiated once.
- The scheduler holds the FSM, shift register, index counter and hit counter.

Test Plan:
- Reset, W=8, MIN_RUN=2: drive rst low mid-SHIFT → in_ready=1, out_valid=0, hit_count=0 immediately; the next word scans normally.
- in_word=8'b0110_1110 → bits 0,1,1,0,1,1,1,0 then 0. out_valid at cycle 11, hit_count=2.
- in_word=8'hFF → single run of 8 ended by the terminator, hit_count=1. in_word=8'h00 → hit_count=0.
- in_word=8'b1010_1010 → hit_count=0 with MIN_RUN=2; rebuild with MIN_RUN=1 → hit_count=4.
- in_word=8'b1101_1011 with MIN_RUN=2 → hit_count=3 (the trailing "11" is counted via FLUSH). Hold out_ready=0 for 5 cycles → out_valid and hit_count stay stable; in_ready stays 0.
- Assert abort at the 4th SHIFT cycle → IDLE next edge, no out_valid pulse. Back-to-back words with in_valid held high → each accepted only in IDLE, giving an 11-cycle spacing from each accept to its out_valid.
